// File: rtl/alu_issue_stage_pkg.sv
// Shared opcode map, flag bit positions and width constants for the ALU issue stage.
package alu_issue_stage_pkg;

    localparam int W    = 16;
    localparam int NOPS = 16;
    localparam int OP_W = 4;

    // Opcode value equals the index of the ALU result slice it selects.
    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,   // x + y
        OP_SUB  = 4'd1,   // x - y
        OP_RSUB = 4'd2,   // y - x
        OP_ZERO = 4'd3,   // 0
        OP_ONE  = 4'd4,   // 1
        OP_MONE = 4'd5,   // -1
        OP_NEGX = 4'd6,   // -x
        OP_NEGY = 4'd7,   // -y
        OP_NOTX = 4'd8,   // ~x
        OP_NOTY = 4'd9,   // ~y
        OP_INCX = 4'd10,  // x + 1
        OP_INCY = 4'd11,  // y + 1
        OP_DECX = 4'd12,  // x - 1
        OP_DECY = 4'd13,  // y - 1
        OP_AND  = 4'd14,  // x & y
        OP_OR   = 4'd15   // x | y
    } alu_op_e;

    // Bit positions inside the {V,N,Z} flag vector.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

endpackage

// File: rtl/alu_issue_stage_flag_gen.sv
// Status flag generator: zero, negative and signed overflow of the selected result.
module alu_flag_gen #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] result,
    input  logic        [3:0]   op,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    output logic        [2:0]   flags
);
    import alu_issue_stage_pkg::*;

    logic sx, sy, sr;

    assign sx = x[W-1];
    assign sy = y[W-1];
    assign sr = result[W-1];

    // Overflow only exists for the add/subtract results; other ops report V=0.
    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = sr;
        case (op)
            OP_ADD:  flags[FLAG_V] = (sx == sy) && (sr != sx);
            OP_SUB:  flags[FLAG_V] = (sx != sy) && (sr != sx);
            OP_RSUB: flags[FLAG_V] = (sy != sx) && (sr != sy);
            default: flags[FLAG_V] = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue wrapper around the combinational ALU: operand register (p0)
// feeding the ALU, then result/flag register (p1) presented downstream.
module alu_issue_stage #(
    parameter int W    = 16,
    parameter int NOPS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [W-1:0]      in_x,
    input  logic [W-1:0]      in_y,
    output logic [W-1:0]      alu_x,
    output logic [W-1:0]      alu_y,
    input  logic [NOPS*W-1:0] alu_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_result,
    output logic [3:0]        out_op,
    output logic [2:0]        out_flags,
    output logic [15:0]       op_count
);
    import alu_issue_stage_pkg::*;

    logic                vld_p0;
    logic [3:0]          op_p0;
    logic signed [W-1:0] x_p0;
    logic signed [W-1:0] y_p0;
    logic signed [W-1:0] sel_res_p0;
    logic [2:0]          flags_p0;
    logic                b_free;
    logic                in_xfer;
    logic                out_xfer;

    assign b_free   = !out_valid || out_ready;
    assign in_ready = !vld_p0 || b_free;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    assign alu_x = x_p0;
    assign alu_y = y_p0;

    // ---- stage p0: operand register driving the ALU ----
    // Capture a new op on input transfer; otherwise drain when stage p1 takes ours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            op_p0  <= '0;
            x_p0   <= '0;
            y_p0   <= '0;
        end else if (in_xfer) begin
            vld_p0 <= 1'b1;
            op_p0  <= in_op;
            x_p0   <= in_x;
            y_p0   <= in_y;
        end else if (b_free) begin
            vld_p0 <= 1'b0;
        end
    end

    // Pick the ALU result bus addressed by the registered opcode.
    always_comb begin
        sel_res_p0 = '0;
        for (int i = 0; i < NOPS; i++) begin
            if (op_p0 == 4'(i)) sel_res_p0 = alu_res[W*i +: W];
        end
    end

    alu_flag_gen #(.W(W)) u_flag_gen (
        .result (sel_res_p0),
        .op     (op_p0),
        .x      (x_p0),
        .y      (y_p0),
        .flags  (flags_p0)
    );

    // ---- stage p1: registered result presented downstream ----
    // Advance only when the output slot is free so held results stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_op     <= '0;
            out_flags  <= '0;
        end else if (b_free) begin
            out_valid <= vld_p0;
            if (vld_p0) begin
                out_result <= sel_res_p0;
                out_op     <= op_p0;
                out_flags  <= flags_p0;
            end
        end
    end

    // Count results accepted downstream; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_xfer) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule
